// File: rtl/regfile_writeback_unit_if.sv
// ---------------------------------------------------------------------------
// regfile_writeback_unit_if
//
// Bundles every non-clock/reset signal of the register-file writeback unit.
//
//   ALU result path   : alu_valid, alu_rd, alu_data        (master -> slave)
//   Load response path: mem_valid, mem_rd, mem_data        (master -> slave)
//                       mem_ready                          (slave -> master)
//   Load issue        : issue_load, issue_rd               (master -> slave)
//   Decode hazard     : rs1, rs2                           (master -> slave)
//                       stall                              (slave -> master)
//   Regfile write port: reg_write, rd, write_data          (slave -> master)
//   Status            : fifo_count                         (slave -> master)
//
// The slave modport is used by the writeback unit. The master modport is
// used by whatever drives it (pipeline stages, or a testbench).
// ---------------------------------------------------------------------------
interface regfile_writeback_unit_if #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 4
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             alu_valid;
  logic [4:0]       alu_rd;
  logic [XLEN-1:0]  alu_data;

  logic             mem_valid;
  logic [4:0]       mem_rd;
  logic [XLEN-1:0]  mem_data;
  logic             mem_ready;

  logic             issue_load;
  logic [4:0]       issue_rd;

  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic             stall;

  logic             reg_write;
  logic [4:0]       rd;
  logic [XLEN-1:0]  write_data;

  logic [CNT_W-1:0] fifo_count;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    input  mem_ready,
    output issue_load, issue_rd,
    output rs1, rs2,
    input  stall,
    input  reg_write, rd, write_data,
    input  fifo_count
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    output mem_ready,
    input  issue_load, issue_rd,
    input  rs1, rs2,
    output stall,
    output reg_write, rd, write_data,
    output fifo_count
  );

endinterface

// File: rtl/regfile_writeback_unit.sv
// ---------------------------------------------------------------------------
// regfile_writeback_unit
//
// Write-side driver for the 32x32 register file. Two result sources share
// the file's single write port:
//   - the ALU path (single cycle, always accepted, highest priority)
//   - the load-response path, buffered in a FIFO_DEPTH-entry FIFO
// A 32-bit scoreboard tracks registers with an outstanding load and raises
// a decode stall when a decode source register is still pending.
//
// Ports:
//   clk    : clock, all state updates on the rising edge
//   rst    : asynchronous, active-high reset
//   wb_if  : regfile_writeback_unit_if.slave (see interface file for the
//            full signal list: ALU/load inputs, load issue, decode sources,
//            stall, registered write port and FIFO occupancy)
// ---------------------------------------------------------------------------
module regfile_writeback_unit #(
  parameter int FIFO_DEPTH = 4,
  parameter int XLEN       = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  regfile_writeback_unit_if.slave wb_if
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // FIFO storage; contents are only meaningful below count_q, so no reset
  logic [4:0]       fifoRd_q   [FIFO_DEPTH];
  logic [XLEN-1:0]  fifoData_q [FIFO_DEPTH];

  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Registered write port plus a tag saying the write came from the FIFO
  logic             regWrite_q, regWrite_d;
  logic [4:0]       rd_q, rd_d;
  logic [XLEN-1:0]  writeData_q, writeData_d;
  logic             fromFifo_q, fromFifo_d;

  logic [31:0]      pending_q, pending_d;

  logic             memReady;
  logic             aluSel;
  logic             popSel;
  logic             pushFire;
  logic             pushStore;

  // Handshake and source selection. The ALU path always wins; a write to
  // x0 is not a write, so it leaves the port free for a FIFO pop.
  // mem_ready is held low while reset is asserted.
  always_comb begin
    memReady  = !rst && (count_q < CNT_W'(FIFO_DEPTH));
    aluSel    = wb_if.alu_valid && (wb_if.alu_rd != 5'd0);
    popSel    = !aluSel && (count_q != '0);
    pushFire  = wb_if.mem_valid && memReady;
    // Responses to x0 are handshaked but never take a slot
    pushStore = pushFire && (wb_if.mem_rd != 5'd0);
  end

  // Next-state for the registered write port. When nothing is selected,
  // rd and write_data keep their previous values.
  always_comb begin
    regWrite_d  = 1'b0;
    rd_d        = rd_q;
    writeData_d = writeData_q;
    fromFifo_d  = 1'b0;
    if (aluSel) begin
      regWrite_d  = 1'b1;
      rd_d        = wb_if.alu_rd;
      writeData_d = wb_if.alu_data;
    end else if (popSel) begin
      regWrite_d  = 1'b1;
      rd_d        = fifoRd_q[rdPtr_q];
      writeData_d = fifoData_q[rdPtr_q];
      fromFifo_d  = 1'b1;
    end
  end

  // FIFO pointer and occupancy update. Pointers wrap naturally because the
  // depth is a power of two.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (pushStore) begin
      wrPtr_d = wrPtr_q + PTR_W'(1);
    end
    if (popSel) begin
      rdPtr_d = rdPtr_q + PTR_W'(1);
    end
    case ({pushStore, popSel})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Scoreboard. A FIFO-sourced write clears its bit at the edge ending the
  // cycle it is on the port; a new issue to the same register at that edge
  // is applied afterwards so the set wins.
  always_comb begin
    pending_d = pending_q;
    if (regWrite_q && fromFifo_q) begin
      pending_d[rd_q] = 1'b0;
    end
    if (wb_if.issue_load && (wb_if.issue_rd != 5'd0)) begin
      pending_d[wb_if.issue_rd] = 1'b1;
    end
  end

  // FIFO data array write
  always_ff @(posedge clk) begin
    if (pushStore) begin
      fifoRd_q[wrPtr_q]   <= wb_if.mem_rd;
      fifoData_q[wrPtr_q] <= wb_if.mem_data;
    end
  end

  // Control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      regWrite_q  <= 1'b0;
      rd_q        <= 5'd0;
      writeData_q <= '0;
      fromFifo_q  <= 1'b0;
      pending_q   <= '0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      regWrite_q  <= regWrite_d;
      rd_q        <= rd_d;
      writeData_q <= writeData_d;
      fromFifo_q  <= fromFifo_d;
      pending_q   <= pending_d;
    end
  end

  // x0 never stalls decode
  always_comb begin
    wb_if.stall = ((wb_if.rs1 != 5'd0) && pending_q[wb_if.rs1]) ||
                  ((wb_if.rs2 != 5'd0) && pending_q[wb_if.rs2]);
  end

  assign wb_if.mem_ready  = memReady;
  assign wb_if.reg_write  = regWrite_q;
  assign wb_if.rd         = rd_q;
  assign wb_if.write_data = writeData_q;
  assign wb_if.fifo_count = count_q;

endmodule

// File: tb/tb_regfile_writeback_unit.sv
// ---------------------------------------------------------------------------
// tb_regfile_writeback_unit
//
// Directed testbench for regfile_writeback_unit. Inputs change 1 time unit
// after a rising edge; outputs are checked 1 time unit later, so every
// check sees the combinational and registered values of that cycle.
// ---------------------------------------------------------------------------
module tb_regfile_writeback_unit;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  regfile_writeback_unit_if #(.XLEN(32), .FIFO_DEPTH(4)) bus ();

  regfile_writeback_unit #(.FIFO_DEPTH(4), .XLEN(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .wb_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid  = 1'b0;
    bus.alu_rd     = 5'd0;
    bus.alu_data   = 32'h0;
    bus.mem_valid  = 1'b0;
    bus.mem_rd     = 5'd0;
    bus.mem_data   = 32'h0;
    bus.issue_load = 1'b0;
    bus.issue_rd   = 5'd0;
    bus.rs1        = 5'd0;
    bus.rs2        = 5'd0;
  endtask

  // Everything must be cleared while reset is held; mem_ready rises after
  task automatic test_reset();
    #2;
    checks++; if (bus.reg_write !== 1'b0) begin failures++; $display("[TB] FAIL rst_we got=%0b exp=0", bus.reg_write); end
    checks++; if (bus.rd !== 5'd0) begin failures++; $display("[TB] FAIL rst_rd got=%0d exp=0", bus.rd); end
    checks++; if (bus.write_data !== 32'h0) begin failures++; $display("[TB] FAIL rst_data got=%h exp=0", bus.write_data); end
    checks++; if (bus.fifo_count !== 3'd0) begin failures++; $display("[TB] FAIL rst_count got=%0d exp=0", bus.fifo_count); end
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("[TB] FAIL rst_stall got=%0b exp=0", bus.stall); end
    checks++; if (bus.mem_ready !== 1'b0) begin failures++; $display("[TB] FAIL rst_ready got=%0b exp=0", bus.mem_ready); end
    nextCycle();
    rst = 1'b0;
    #1;
    checks++; if (bus.mem_ready !== 1'b1) begin failures++; $display("[TB] FAIL post_rst_ready got=%0b exp=1", bus.mem_ready); end
  endtask

  // Single ALU write appears one cycle later, then the port goes idle
  task automatic test_alu();
    nextCycle(); idle();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'h1234;
    nextCycle(); idle(); #1;
    checks++; if (bus.reg_write !== 1'b1) begin failures++; $display("[TB] FAIL alu_we got=%0b exp=1", bus.reg_write); end
    checks++; if (bus.rd !== 5'd5) begin failures++; $display("[TB] FAIL alu_rd got=%0d exp=5", bus.rd); end
    checks++; if (bus.write_data !== 32'h1234) begin failures++; $display("[TB] FAIL alu_data got=%h exp=1234", bus.write_data); end
    nextCycle(); #1;
    checks++; if (bus.reg_write !== 1'b0) begin failures++; $display("[TB] FAIL alu_idle_we got=%0b exp=0", bus.reg_write); end
    checks++; if (bus.rd !== 5'd5 || bus.write_data !== 32'h1234) begin failures++; $display("[TB] FAIL alu_hold got=%0d/%h exp=5/1234", bus.rd, bus.write_data); end
  endtask

  // Load issue sets stall; response at N writes at N+2, stall drops at N+3
  task automatic test_load_stall();
    nextCycle(); idle();
    bus.issue_load = 1'b1; bus.issue_rd = 5'd7;
    nextCycle(); idle(); bus.rs1 = 5'd7; #1;
    checks++; if (bus.stall !== 1'b1) begin failures++; $display("[TB] FAIL ld_stall_set got=%0b exp=1", bus.stall); end
    nextCycle(); idle(); bus.rs1 = 5'd7;
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd7; bus.mem_data = 32'hDEADBEEF; #1;
    checks++; if (bus.mem_ready !== 1'b1) begin failures++; $display("[TB] FAIL ld_ready got=%0b exp=1", bus.mem_ready); end
    nextCycle(); idle(); bus.rs1 = 5'd7; #1;
    checks++; if (bus.fifo_count !== 3'd1 || bus.reg_write !== 1'b0) begin failures++; $display("[TB] FAIL ld_n1 got=count%0d/we%0b exp=count1/we0", bus.fifo_count, bus.reg_write); end
    checks++; if (bus.stall !== 1'b1) begin failures++; $display("[TB] FAIL ld_stall_n1 got=%0b exp=1", bus.stall); end
    nextCycle(); idle(); bus.rs1 = 5'd7; #1;
    checks++; if (bus.reg_write !== 1'b1 || bus.rd !== 5'd7 || bus.write_data !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL ld_write got=%0b/%0d/%h exp=1/7/deadbeef", bus.reg_write, bus.rd, bus.write_data); end
    checks++; if (bus.stall !== 1'b1 || bus.fifo_count !== 3'd0) begin failures++; $display("[TB] FAIL ld_n2 got=stall%0b/count%0d exp=stall1/count0", bus.stall, bus.fifo_count); end
    nextCycle(); idle(); bus.rs1 = 5'd7; #1;
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("[TB] FAIL ld_stall_clear got=%0b exp=0", bus.stall); end
    checks++; if (bus.reg_write !== 1'b0) begin failures++; $display("[TB] FAIL ld_n3_we got=%0b exp=0", bus.reg_write); end
  endtask

  // ALU traffic holds off the FIFO pop until the ALU goes quiet
  task automatic test_alu_priority();
    nextCycle(); idle();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_data = 32'h44;
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd3; bus.mem_data = 32'hA;
    for (int i = 1; i <= 3; i++) begin
      nextCycle(); idle();
      if (i < 3) begin
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_data = 32'h44 + i;
      end
      #1;
      checks++; if (bus.reg_write !== 1'b1 || bus.rd !== 5'd4 || bus.write_data !== 32'h44 + i - 1) begin failures++; $display("[TB] FAIL prio_alu%0d got=%0b/%0d/%h exp=1/4/%h", i, bus.reg_write, bus.rd, bus.write_data, 32'h44 + i - 1); end
      checks++; if (bus.fifo_count !== 3'd1) begin failures++; $display("[TB] FAIL prio_count%0d got=%0d exp=1", i, bus.fifo_count); end
    end
    nextCycle(); idle(); #1;
    checks++; if (bus.reg_write !== 1'b1 || bus.rd !== 5'd3 || bus.write_data !== 32'hA) begin failures++; $display("[TB] FAIL prio_load got=%0b/%0d/%h exp=1/3/a", bus.reg_write, bus.rd, bus.write_data); end
    checks++; if (bus.fifo_count !== 3'd0) begin failures++; $display("[TB] FAIL prio_drained got=%0d exp=0", bus.fifo_count); end
  endtask

  // Fill to depth while the ALU is busy, reject the 5th, drain in order
  // across the pointer wrap (pointers start at 2 here)
  task automatic test_fifo_full();
    logic [31:0] expData;
    for (int k = 0; k < 5; k++) begin
      nextCycle(); idle();
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'(k);
      bus.mem_valid = 1'b1; bus.mem_rd = 5'(10 + k); bus.mem_data = 32'h100 + 32'(k);
      #1;
      checks++; if (bus.mem_ready !== (k < 4)) begin failures++; $display("[TB] FAIL full_ready%0d got=%0b exp=%0b", k, bus.mem_ready, (k < 4)); end
      checks++; if (bus.fifo_count !== 3'(k)) begin failures++; $display("[TB] FAIL full_count%0d got=%0d exp=%0d", k, bus.fifo_count, k); end
    end
    nextCycle(); idle();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'h77; #1;
    checks++; if (bus.fifo_count !== 3'd4 || bus.mem_ready !== 1'b0) begin failures++; $display("[TB] FAIL full_hold got=count%0d/ready%0b exp=count4/ready0", bus.fifo_count, bus.mem_ready); end
    nextCycle(); idle(); #1;
    for (int j = 0; j < 5; j++) begin
      nextCycle(); idle();
      if (j == 0) begin
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd14; bus.mem_data = 32'h1AA;
      end
      #1;
      expData = (j < 4) ? 32'h100 + 32'(j) : 32'h1AA;
      checks++; if (bus.reg_write !== 1'b1 || bus.rd !== 5'(10 + j) || bus.write_data !== expData) begin failures++; $display("[TB] FAIL drain%0d got=%0b/%0d/%h exp=1/%0d/%h", j, bus.reg_write, bus.rd, bus.write_data, 10 + j, expData); end
      checks++; if (bus.fifo_count !== ((j == 0) ? 3'd3 : 3'(4 - j))) begin failures++; $display("[TB] FAIL drain_count%0d got=%0d exp=%0d", j, bus.fifo_count, (j == 0) ? 3 : 4 - j); end
    end
    nextCycle(); idle(); #1;
    checks++; if (bus.reg_write !== 1'b0) begin failures++; $display("[TB] FAIL drain_idle got=%0b exp=0", bus.reg_write); end
  endtask

  // Re-issue to rd=9 in the writeback cycle keeps the pending bit set
  task automatic test_set_clear();
    nextCycle(); idle();
    bus.issue_load = 1'b1; bus.issue_rd = 5'd9;
    nextCycle(); idle(); bus.rs2 = 5'd9;
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd9; bus.mem_data = 32'h99; #1;
    checks++; if (bus.stall !== 1'b1) begin failures++; $display("[TB] FAIL sc_stall_n got=%0b exp=1", bus.stall); end
    nextCycle(); idle(); bus.rs2 = 5'd9;
    nextCycle(); idle(); bus.rs2 = 5'd9;
    bus.issue_load = 1'b1; bus.issue_rd = 5'd9; #1;
    checks++; if (bus.reg_write !== 1'b1 || bus.rd !== 5'd9 || bus.write_data !== 32'h99) begin failures++; $display("[TB] FAIL sc_write got=%0b/%0d/%h exp=1/9/99", bus.reg_write, bus.rd, bus.write_data); end
    nextCycle(); idle(); bus.rs2 = 5'd9;
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd9; bus.mem_data = 32'h199; #1;
    checks++; if (bus.stall !== 1'b1) begin failures++; $display("[TB] FAIL sc_set_wins got=%0b exp=1", bus.stall); end
    nextCycle(); idle(); bus.rs2 = 5'd9; #1;
    checks++; if (bus.stall !== 1'b1) begin failures++; $display("[TB] FAIL sc_stall_n4 got=%0b exp=1", bus.stall); end
    nextCycle(); idle(); bus.rs2 = 5'd9; #1;
    checks++; if (bus.reg_write !== 1'b1 || bus.rd !== 5'd9 || bus.write_data !== 32'h199) begin failures++; $display("[TB] FAIL sc_write2 got=%0b/%0d/%h exp=1/9/199", bus.reg_write, bus.rd, bus.write_data); end
    nextCycle(); idle(); bus.rs2 = 5'd9; #1;
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("[TB] FAIL sc_stall_clear got=%0b exp=0", bus.stall); end
  endtask

  // x0 destinations never write; an ALU x0 result leaves room for a pop
  task automatic test_zero_rd();
    nextCycle(); idle();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'hFF;
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd0; bus.mem_data = 32'hEE;
    bus.issue_load = 1'b1; bus.issue_rd = 5'd0; #1;
    checks++; if (bus.mem_ready !== 1'b1) begin failures++; $display("[TB] FAIL z_ready got=%0b exp=1", bus.mem_ready); end
    nextCycle(); idle(); #1;
    checks++; if (bus.reg_write !== 1'b0 || bus.fifo_count !== 3'd0) begin failures++; $display("[TB] FAIL z_nowrite got=we%0b/count%0d exp=we0/count0", bus.reg_write, bus.fifo_count); end
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd6; bus.mem_data = 32'h66;
    nextCycle(); idle();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'hFF; #1;
    checks++; if (bus.reg_write !== 1'b0 || bus.fifo_count !== 3'd1) begin failures++; $display("[TB] FAIL z_queued got=we%0b/count%0d exp=we0/count1", bus.reg_write, bus.fifo_count); end
    nextCycle(); idle(); #1;
    checks++; if (bus.reg_write !== 1'b1 || bus.rd !== 5'd6 || bus.write_data !== 32'h66) begin failures++; $display("[TB] FAIL z_pop got=%0b/%0d/%h exp=1/6/66", bus.reg_write, bus.rd, bus.write_data); end
    checks++; if (bus.fifo_count !== 3'd0) begin failures++; $display("[TB] FAIL z_pop_count got=%0d exp=0", bus.fifo_count); end
  endtask

  // Reset with two buffered responses discards them and the pending bit
  task automatic test_reset_mid();
    nextCycle(); idle();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd2; bus.alu_data = 32'h2;
    bus.issue_load = 1'b1; bus.issue_rd = 5'd20;
    nextCycle(); idle(); bus.rs1 = 5'd20;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd2; bus.alu_data = 32'h2;
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd20; bus.mem_data = 32'h20;
    nextCycle(); idle(); bus.rs1 = 5'd20;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd2; bus.alu_data = 32'h2;
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd21; bus.mem_data = 32'h21;
    nextCycle(); idle(); bus.rs1 = 5'd20;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd2; bus.alu_data = 32'h2; #1;
    checks++; if (bus.fifo_count !== 3'd2 || bus.stall !== 1'b1 || bus.reg_write !== 1'b1) begin failures++; $display("[TB] FAIL rm_pre got=count%0d/stall%0b/we%0b exp=count2/stall1/we1", bus.fifo_count, bus.stall, bus.reg_write); end
    rst = 1'b1; #1;
    checks++; if (bus.reg_write !== 1'b0 || bus.fifo_count !== 3'd0) begin failures++; $display("[TB] FAIL rm_async got=we%0b/count%0d exp=we0/count0", bus.reg_write, bus.fifo_count); end
    checks++; if (bus.stall !== 1'b0 || bus.mem_ready !== 1'b0) begin failures++; $display("[TB] FAIL rm_async2 got=stall%0b/ready%0b exp=stall0/ready0", bus.stall, bus.mem_ready); end
    nextCycle();
    nextCycle(); idle(); bus.rs1 = 5'd20;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      nextCycle(); idle(); bus.rs1 = 5'd20; #1;
      checks++; if (bus.reg_write !== 1'b0 || bus.fifo_count !== 3'd0 || bus.stall !== 1'b0) begin failures++; $display("[TB] FAIL rm_after%0d got=we%0b/count%0d/stall%0b exp=0/0/0", c, bus.reg_write, bus.fifo_count, bus.stall); end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle();
    $display("[TB] starting regfile_writeback_unit tests");
    test_reset();
    test_alu();
    test_load_stall();
    test_alu_priority();
    test_fifo_full();
    test_set_clear();
    test_zero_rd();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_writeback_unit.md
Name: regfile_writeback_unit

Overview:
Write-side driver for the 32x32 register file. Merges two result sources into the file's single synchronous write port (reg_write/rd/write_data): the single-cycle ALU path and the multi-cycle load-response path. Load responses are buffered in a small FIFO. A 32-bit scoreboard of outstanding load destinations generates a decode-stage stall for read-after-write hazards. Sits between execute/memory stages and the register file.

Parameters:
FIFO_DEPTH, 4, load-response buffer entries (power of 2, >=2)
XLEN, 32, data width

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high reset
alu_valid  in  1  ALU result valid this cycle (always accepted)
alu_rd  in  5  ALU destination register
alu_data  in  XLEN  ALU result
mem_valid  in  1  load response valid
mem_rd  in  5  load destination register
mem_data  in  XLEN  load data
mem_ready  out  1  FIFO can accept a response
issue_load  in  1  load issued this cycle; mark issue_rd pending
issue_rd  in  5  destination of issued load
rs1  in  5  decode-stage source 1
rs2  in  5  decode-stage source 2
stall  out  1  decode must hold (source pending)
reg_write  out  1  register file write enable (registered)
rd  out  5  register file write address (registered)
write_data  out  XLEN  register file write data (registered)
fifo_count  out  $clog2(FIFO_DEPTH)+1  entries in FIFO

Behaviour:
- Reset (async, while reset=1): reg_write=0, rd=0, write_data=0, FIFO empty, fifo_count=0, scoreboard all 0, stall=0, mem_ready=0. After reset deasserts, mem_ready=1. Reset mid-operation discards FIFO contents and pending bits.
- Output stage is a register: values on reg_write/rd/write_data in cycle N+1 reflect the selection made in cycle N. The register file captures them at the edge ending cycle N+1.
- Selection each cycle, priority order:
  (1) alu_valid=1 and alu_rd!=0: next-cycle write of alu_rd/alu_data. ALU latency is 1.
  (2) otherwise, if the FIFO is non-empty: pop the head; next-cycle write of its rd/data.
  (3) otherwise: next-cycle reg_write=0. rd and write_data hold their previous values.
- alu_valid with alu_rd=0: no write. The FIFO may pop in that cycle.
- FIFO push: occurs when mem_valid=1 and mem_ready=1. A response with mem_rd=0 is accepted but not stored.
- mem_ready = (fifo_count < FIFO_DEPTH), combinational.
- mem_valid while full: ignored, no state change (protocol error).
- Push and pop in the same cycle are allowed; count is unchanged. A response pushed in cycle N can pop in cycle N+1 at the earliest, so it appears on reg_write in cycle N+2 (minimum load latency 2).
- Pointers wrap modulo FIFO_DEPTH. Order is strictly FIFO.
- Scoreboard:
  - issue_load=1 and issue_rd!=0 sets pending[issue_rd].
  - pending[r] clears at the edge ending the cycle in which reg_write=1 with rd=r and the entry came from the FIFO path.
  - Set and clear of the same r at the same edge: set wins.
  - ALU writes never clear pending bits.
- stall = (rs1!=0 and pending[rs1]) or (rs2!=0 and pending[rs2]), combinational. It deasserts in the cycle after the load write is on the port, so decode reads the written value.
- Sustained ALU traffic can starve the FIFO. Back-pressure is via mem_ready only; no starvation timer.

Test Plan:
- Reset then alu_valid=1, alu_rd=5, alu_data=0x1234 for one cycle -> next cycle reg_write=1, rd=5, write_data=0x1234; following cycle reg_write=0.
- issue_load rd=7, then rs1=7 -> stall=1. mem_valid rd=7 data=0xDEADBEEF at cycle N -> reg_write=1, rd=7 at N+2; stall=0 at N+3.
- mem_valid rd=3 data=0xA at cycle N with alu_valid rd=4 continuous for N..N+2 -> writes rd=4 at N+1..N+3; rd=3 at N+4.
- 5 back-to-back responses with ALU busy and depth 4 -> mem_ready=0 after the 4th push, fifo_count=4. The 5th is ignored until a pop. Drain order matches push order across pointer wrap.
- issue_load rd=9 in the same cycle the prior rd=9 load writes back -> pending[9] remains 1 and stall persists for rs2=9. alu_rd=0 and mem_rd=0 -> no reg_write.
- Assert reset with FIFO holding 2 entries -> reg_write=0 immediately, fifo_count=0, stall=0, no writes after release.
